lix_pipe_arb: RTL and testbench
===============================

Name: lix_pipe_arb

Overview:
- Round-robin scheduler that shares one external N-stage enable-gated pipeline (lix_shr1-style: valid/data shift registers advanced by a common enable) among R requesters.
- Arbitrates requests, drives the pipeline's input valid, data and enable, and tracks each requester's ID through an internal N-deep tag pipe.
- Stalls the whole pipeline on downstream backpressure.
- Flags any mismatch between the returned valid and the tracked tag.

Parameters:
- W, 32, data width per requester and pipeline width
- N, 2, depth of the controlled pipeline in stages (N >= 1)
- R, 4, number of requesters (R >= 2)
- IDW, $clog2(R), width of the requester ID

Ports:
- clk_i  input  1  clock, all state on the rising edge
- rst_ni  input  1  asynchronous active-low reset
- i_req  input  R  per-requester request; bit r is held until granted
- i_dat  input  R*W  per-requester data; requester r in bits [r*W +: W]
- o_gnt  output  R  one-hot grant; the transfer occurs in the cycle o_gnt[r]=1
- o_pvld  output  1  pipeline input valid
- o_px  output  W  pipeline input data (winner's data)
- o_en  output  1  pipeline enable, common to all stages
- i_zvld  input  1  pipeline output valid (stage N)
- i_z  input  W  pipeline output data
- o_vld  output  1  downstream valid (= i_zvld)
- o_dat  output  W  downstream data (= i_z)
- o_id  output  IDW  requester ID of the item at o_dat
- i_rdy  input  1  downstream ready
- o_idle  output  1  no tag valid in flight
- o_err  output  1  sticky tag/valid mismatch flag

Behaviour:
- Reset (async, rst_ni=0):
  - round-robin pointer ptr=0
  - all tag valid bits 0, tag IDs 0
  - o_err=0
  - Outputs during reset: o_gnt=0, o_pvld=0, o_en=1, o_idle=1.
- Stall rule (combinational): o_en = ~i_zvld | i_rdy. The pipeline advances every cycle except when stage N holds valid data that downstream has not accepted.
- Arbitration (combinational):
  - The winner is the first r with i_req[r]=1, searching ptr, ptr+1, ... with wrap modulo R.
  - o_gnt[winner] = o_en; all other bits are 0. o_gnt=0 if there is no request or o_en=0.
  - o_pvld = |i_req & o_en.
  - o_px = winner's i_dat, or 0 when there is no request.
  - Combinational paths i_rdy -> o_en -> o_gnt and i_req -> o_gnt are permitted.
- Pointer update: when o_gnt is nonzero, ptr <= (winner+1) mod R. Otherwise ptr holds. This gives fairness: a requester held high is granted within R grant cycles.
- Tag pipe: N stages of {valid, id}.
  - Advances only when o_en=1.
  - Stage 1 receives {|o_gnt, winner}.
  - Stage k receives stage k-1.
  - Holds all stages when o_en=0.
- Outputs from the tag pipe:
  - o_id = id of stage N.
  - o_idle = ~|(tag valids).
- Latency: a grant in cycle t with no stalls gives o_vld=1, o_dat=granted data and o_id=r in cycle t+N. Each stall cycle adds exactly one cycle.
- Throughput: one item per cycle when i_rdy=1 continuously.
- Check: in any cycle where i_zvld != stage-N tag valid, o_err <= 1. o_err is cleared only by reset.
- Boundaries:
  - Simultaneous downstream accept and new grant in the same cycle is allowed (o_en=1).
  - Stall with all N stages full: no grant, no data lost, o_dat and o_id stable until i_rdy.
  - A request arriving during a stall waits; o_gnt=0 throughout.
  - Reset mid-operation clears the tags. The external pipeline shares rst_ni, so no mismatch results.
  - R not a power of 2: ptr wraps at R-1 -> 0, never reaching an invalid index.

Test Plan:
1. Reset, then single request: i_req=4'b0100, i_dat[2]=32'hA5A5_0002, i_rdy=1 -> o_gnt=4'b0100 for 1 cycle; o_vld=1, o_dat=32'hA5A5_0002, o_id=2 exactly N=2 cycles later; o_idle returns to 1.
2. Fairness: i_req=4'b1111 held, i_rdy=1 -> grants in order 0,1,2,3,0,... one per cycle; o_id sequence 0,1,2,3 starting at cycle 2.
3. Backpressure: stream from requester 1, drop i_rdy for 3 cycles while o_vld=1 -> o_en=0 and o_gnt=0 for those 3 cycles; o_dat/o_id held; no item lost or duplicated after i_rdy=1.
4. Pointer skip: ptr=1, i_req=4'b0001 -> grant 0, ptr becomes 1; next i_req=4'b1001 -> grant 3 (search starts at 1).
5. Mismatch injection: bench forces i_zvld=1 while the stage-N tag is empty -> o_err=1 next cycle and stays 1 until rst_ni=0.
6. Async reset while 2 items are in flight -> o_gnt=0, o_idle=1, o_err=0 immediately; after release a new grant to requester 0 (ptr=0).

Source files
------------

// File: rtl/lix_pipe_arb.sv
// Round-robin scheduler that shares one enable-gated N-stage pipeline among R
// requesters, carrying each winner's ID alongside the data through a tag pipe.

module lix_pipe_arb_tag_stage #(
    parameter int IDW = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en,
    input  logic           d_vld,
    input  logic [IDW-1:0] d_id,
    output logic           q_vld,
    output logic [IDW-1:0] q_id
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_vld <= 1'b0;
            q_id  <= '0;
        end else if (en) begin
            q_vld <= d_vld;
            q_id  <= d_id;
        end
    end
endmodule

module lix_pipe_arb #(
    parameter int W   = 32,
    parameter int N   = 2,
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [R-1:0]   i_req,
    input  logic [R*W-1:0] i_dat,
    output logic [R-1:0]   o_gnt,
    output logic           o_pvld,
    output logic [W-1:0]   o_px,
    output logic           o_en,
    input  logic           i_zvld,
    input  logic [W-1:0]   i_z,
    output logic           o_vld,
    output logic [W-1:0]   o_dat,
    output logic [IDW-1:0] o_id,
    input  logic           i_rdy,
    output logic           o_idle,
    output logic           o_err
);
    logic [R-1:0][W-1:0]   dat_a;
    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        win;
    logic [IDW:0]          idx;
    logic                  found;
    logic                  any;
    logic                  go;
    logic [N:0]            vld_pipe;
    logic [N:0][IDW-1:0]   id_pipe;
    logic                  err;

    assign dat_a = i_dat;
    assign any   = |i_req;

    // Reset forces the enable high and the grant low so nothing launches
    // while the shared external pipeline is also being cleared.
    assign o_en = ~rst_ni | ~i_zvld | i_rdy;
    assign go   = any & o_en & rst_ni;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < R; i++) begin
            idx = {1'b0, ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(R))
                idx = idx - (IDW+1)'(R);
            if (!found && i_req[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    assign o_gnt  = go ? (R'(1) << win) : '0;
    assign o_pvld = go;
    assign o_px   = any ? dat_a[win] : '0;

    // Pointer wraps explicitly at R-1 so non-power-of-2 R never indexes past R-1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            ptr <= '0;
        else if (go)
            ptr <= (win == IDW'(R-1)) ? '0 : win + IDW'(1);
    end

    assign vld_pipe[0] = go;
    assign id_pipe[0]  = win;

    for (genvar k = 1; k <= N; k++) begin : g_tag
        lix_pipe_arb_tag_stage #(.IDW(IDW)) u_stage (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .en    (o_en),
            .d_vld (vld_pipe[k-1]),
            .d_id  (id_pipe[k-1]),
            .q_vld (vld_pipe[k]),
            .q_id  (id_pipe[k])
        );
    end

    assign o_vld  = i_zvld;
    assign o_dat  = i_z;
    assign o_id   = id_pipe[N];
    assign o_idle = ~|vld_pipe[N:1];

    // Sticky: the returned valid must always track the stage-N tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            err <= 1'b0;
        else if (i_zvld != vld_pipe[N])
            err <= 1'b1;
    end

    assign o_err = err;
endmodule

// File: tb/tb_lix_pipe_arb.sv
// Randomized scoreboard bench for lix_pipe_arb with a behavioural arbiter model
// and a model of the external enable-gated pipeline.

module tb_lix_pipe_arb;
    localparam int W   = 32;
    localparam int N   = 2;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [R-1:0]   i_req = '0;
    logic [R*W-1:0] i_dat;
    logic [R-1:0]   o_gnt;
    logic           o_pvld;
    logic [W-1:0]   o_px;
    logic           o_en;
    logic           i_zvld;
    logic [W-1:0]   i_z;
    logic           o_vld;
    logic [W-1:0]   o_dat;
    logic [IDW-1:0] o_id;
    logic           i_rdy = 1'b1;
    logic           o_idle;
    logic           o_err;

    lix_pipe_arb #(.W(W), .N(N), .R(R), .IDW(IDW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .i_req(i_req), .i_dat(i_dat),
        .o_gnt(o_gnt), .o_pvld(o_pvld), .o_px(o_px), .o_en(o_en),
        .i_zvld(i_zvld), .i_z(i_z), .o_vld(o_vld), .o_dat(o_dat),
        .o_id(o_id), .i_rdy(i_rdy), .o_idle(o_idle), .o_err(o_err)
    );

    always #5 clk_i = ~clk_i;

    // External pipeline: valid/data shift registers on the common enable.
    logic [N-1:0]        pv;
    logic [N-1:0][W-1:0] pd;
    logic                inj = 1'b0;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv <= '0;
            pd <= '0;
        end else if (o_en) begin
            for (int k = N-1; k > 0; k--) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
            pv[0] <= o_pvld;
            pd[0] <= o_px;
        end
    end
    assign i_zvld = pv[N-1] | inj;
    assign i_z    = pd[N-1];

    logic [R-1:0][W-1:0] tdat = '0;
    assign i_dat = tdat;

    typedef struct {
        int          id;
        logic [W-1:0] d;
    } exp_t;
    exp_t q[$];

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           mptr = 0;
    int           inflight = 0;
    bit           err_exp = 0;
    logic [R-1:0] mdl_gnt = '0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: arbitration, pointer, in-flight count and error flag.
    int           w;
    bit           en_e;
    logic [R-1:0] eg;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            en_e = !i_zvld || i_rdy;
            w = -1;
            for (int i = 0; i < R; i++)
                if (w < 0 && i_req[(mptr + i) % R]) w = (mptr + i) % R;
            eg = (w >= 0 && en_e) ? R'(1) << w : '0;
            chk("en", 64'(o_en), 64'(en_e));
            chk("gnt", 64'(o_gnt), 64'(eg));
            chk("pvld", 64'(o_pvld), 64'(eg != 0));
            chk("px", 64'(o_px), (w >= 0) ? 64'(tdat[w]) : 64'd0);
            chk("idle", 64'(o_idle), 64'(inflight == 0));
            chk("err", 64'(o_err), 64'(err_exp));
            if (eg != 0) begin
                q.push_back('{id: w, d: tdat[w]});
                mptr = (w + 1) % R;
                inflight++;
            end
            if (i_zvld && i_rdy && !inj) inflight--;
            if (inj) err_exp = 1;
            mdl_gnt = eg;
        end
    end

    // Scoreboard monitor: every accepted output pops one expected item.
    exp_t e;
    always @(negedge clk_i) begin
        if (rst_ni && o_vld && i_rdy && !inj) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra act=%0h exp=none", o_dat);
            end else begin
                e = q.pop_front();
                chk("sb_dat", 64'(o_dat), 64'(e.d));
                chk("sb_id", 64'(o_id), 64'(e.id));
            end
        end
    end

    // Drop granted requests, raise newreq bits (fresh data when newly raised).
    task automatic step(input logic [R-1:0] newreq, input logic rdy);
        logic [R-1:0] cur;
        @(posedge clk_i);
        #1;
        cur = i_req & ~mdl_gnt;
        for (int r = 0; r < R; r++)
            if (newreq[r] && !cur[r]) tdat[r] = $urandom;
        i_req = cur | newreq;
        i_rdy = rdy;
    endtask

    task automatic model_reset();
        mptr = 0;
        inflight = 0;
        err_exp = 0;
        mdl_gnt = '0;
        q.delete();
    endtask

    initial begin
        int  t0;
        bit  seen;
        #1;
        chk("rst_gnt", 64'(o_gnt), 64'd0);
        chk("rst_pvld", 64'(o_pvld), 64'd0);
        chk("rst_en", 64'(o_en), 64'd1);
        chk("rst_idle", 64'(o_idle), 64'd1);
        chk("rst_err", 64'(o_err), 64'd0);
        #11 rst_ni = 1'b1;

        // 1: single request, latency N
        @(posedge clk_i);
        #1;
        tdat[2] = 32'hA5A5_0002;
        i_req = 4'b0100;
        seen = 0;
        t0 = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk_i);
            if (o_gnt != 0) begin seen = 1; t0 = cyc; end
        end
        chk("t1_gnt_seen", 64'(seen), 64'd1);
        step(4'b0000, 1'b1);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk_i);
            if (o_vld) seen = 1;
        end
        chk("t1_vld_seen", 64'(seen), 64'd1);
        chk("t1_lat", 64'(cyc - t0), 64'(N));
        chk("t1_dat", 64'(o_dat), 64'h0000_0000_A5A5_0002);
        repeat (3) step(4'b0000, 1'b1);

        // 2: fairness with all requesters held
        repeat (10) step(4'b1111, 1'b1);
        repeat (4) step(4'b0000, 1'b1);

        // 3: backpressure on a stream from requester 1
        repeat (4) step(4'b0010, 1'b1);
        repeat (3) step(4'b0010, 1'b0);
        repeat (4) step(4'b0010, 1'b1);
        repeat (4) step(4'b0000, 1'b1);

        // 4: pointer skip
        rst_ni = 1'b0;
        model_reset();
        i_req = '0;
        #2 rst_ni = 1'b1;
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b1001, 1'b1);
        repeat (5) step(4'b0000, 1'b1);

        // 5: mismatch injection
        @(posedge clk_i);
        #1 inj = 1'b1;
        @(posedge clk_i);
        #1 inj = 1'b0;
        repeat (5) step(4'b0000, 1'b1);
        chk("t5_err_sticky", 64'(o_err), 64'd1);

        // 6: async reset with two items in flight
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0011, 1'b1);
        #3 rst_ni = 1'b0;
        #1;
        chk("t6_gnt", 64'(o_gnt), 64'd0);
        chk("t6_idle", 64'(o_idle), 64'd1);
        chk("t6_err", 64'(o_err), 64'd0);
        model_reset();
        i_req = '0;
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        step(4'b1111, 1'b1);
        @(negedge clk_i);
        chk("t6_gnt0", 64'(o_gnt), 64'd1);
        repeat (4) step(4'b0000, 1'b1);

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++)
            step(R'($urandom_range(0, 15)) & R'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        repeat (10) step(4'b0000, 1'b1);
        @(negedge clk_i);
        chk("drain", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end
endmodule
